// File: rtl/bcd_convert_seq.sv
// bcd_convert_seq: iterative signed-binary to sign+BCD converter, one double-dabble step per clock.
// Define BCD_BLANK_EN to replace leading zero digits with 4'hF in the output.
module bcd_convert_seq #(
    parameter int IN_W   = 15,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W:0]         din,
    output logic                  busy,
    output logic                  done,
    output logic                  sign,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam int CW = $clog2(IN_W + 2);
`ifdef BCD_BLANK_EN
    localparam logic [4*DIGITS-1:0] BCD_RST = {{(DIGITS-1){4'hF}}, 4'h0};
`else
    localparam logic [4*DIGITS-1:0] BCD_RST = '0;
`endif

    logic [1:0]          state;
    logic [CW-1:0]       cnt;
    logic [4*DIGITS-1:0] acc;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] shown;
    logic [IN_W:0]       mag;
    logic                sign_r;

    always_comb begin
        adj = acc;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = acc[4*i +: 4] > 4'd4 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    end

`ifdef BCD_BLANK_EN
    logic lead;
    // Walk down from the top digit; blank while every digit seen so far is zero.
    always_comb begin
        shown = acc;
        lead  = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lead = lead && (acc[4*i +: 4] == 4'h0);
            shown[4*i +: 4] = lead ? 4'hF : acc[4*i +: 4];
        end
    end
`else
    assign shown = acc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mag    <= '0;
            sign_r <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sign   <= 1'b0;
            bcd    <= BCD_RST;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sign_r <= din[IN_W];
                    // -2^IN_W negates to itself, which reads as +2^IN_W unsigned
                    mag    <= din[IN_W] ? -din : din;
                    acc    <= '0;
                    cnt    <= CW'(IN_W + 1);
                    busy   <= 1'b1;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    {acc, mag} <= {adj, mag} << 1;
                    cnt        <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= DONE;
                end
                DONE: begin
                    bcd   <= shown;
                    sign  <= sign_r;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_convert_seq.sv
// tb_bcd_convert_seq: scoreboard bench for bcd_convert_seq with a decimal-arithmetic reference model.
module tb_bcd_convert_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] din = '0;
    logic        busy, done, sign;
    logic [19:0] bcd;

    typedef struct {
        logic        s;
        logic [19:0] b;
        int          t;
    } exp_t;

`ifdef BCD_BLANK_EN
    localparam logic [20:0] RST_OUT = {1'b0, 20'hFFFF0};
`else
    localparam logic [20:0] RST_OUT = '0;
`endif

    exp_t        q[$];
    int          cmp = 0;
    int          errs = 0;
    int          cyc = 0;
    int          busy_cnt = 0;
    logic [20:0] last_out = RST_OUT;

    bcd_convert_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din),
        .busy(busy), .done(done), .sign(sign), .bcd(bcd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [20:0] model(input logic signed [15:0] v);
        int          m;
        logic [19:0] b;
        m = v < 0 ? -int'(v) : int'(v);
        for (int i = 0; i < 5; i++) begin
            b[4*i +: 4] = 4'((m / (10 ** i)) % 10);
`ifdef BCD_BLANK_EN
            if (i > 0 && m < 10 ** i) b[4*i +: 4] = 4'hF;
`endif
        end
        return {v < 0, b};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_cnt++;
        if (done) begin
            if (q.size() == 0) begin
                cmp++;
                errs++;
                $display("FAIL unexpected_done: got done=1 expected no pending conversion (t=%0t)", $time);
            end else begin
                e = q.pop_front();
                chk("sign", 32'(sign), 32'(e.s));
                chk("bcd", 32'(bcd), 32'(e.b));
                chk("latency", 32'(cyc - e.t), 32'd17);
                chk("busy_cycles", 32'(busy_cnt), 32'd17);
                last_out = {e.s, e.b};
            end
            busy_cnt = 0;
        end else begin
            chk("hold", 32'({sign, bcd}), 32'(last_out));
        end
    end

    task automatic convert(input logic [15:0] v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        if (busy) begin
            cmp++;
            errs++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0 within 100 cycles");
        end
        start = 1'b1;
        din   = v;
        q.push_back('{s: model(v)[20], b: model(v)[19:0], t: cyc + 1});
        @(negedge clk);
        start = 1'b0;
        din   = 16'($urandom);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out", 32'({sign, bcd}), 32'(RST_OUT));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        convert(16'd12345);
        convert(16'hFFFF);
        convert(16'h8000);
        convert(16'd0);
        convert(16'd32767);
        // A start mid-conversion must be dropped without queueing
        convert(16'd12345);
        repeat (5) @(negedge clk);
        start = 1'b1;
        din   = 16'd99;
        @(negedge clk);
        start = 1'b0;
        // Abort a conversion with an asynchronous reset in its eighth cycle
        convert(16'd4321);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        last_out = RST_OUT;
        busy_cnt = 0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out", 32'({sign, bcd}), 32'(RST_OUT));
        @(negedge clk);
        rst_n = 1'b1;
        convert(16'd777);
        convert(16'hFC18);
        for (int k = 0; k < 150; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            convert(16'($urandom));
        end
        for (int k = 0; k < 40 && q.size() != 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
